// File: rtl/pio_tctrl_pkg.sv
// rtl/pio_tctrl_pkg.sv - shared state encodings and defaults for the PIO timing controller
package pio_tctrl_pkg;

    localparam int TWIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T1   = 2'd1,
        ST_T2   = 2'd2,
        ST_TEOC = 2'd3
    } state_e;

endpackage

// File: rtl/pio_tctrl_ud_cnt.sv
// rtl/pio_tctrl_ud_cnt.sv - loadable up/down timing counter
// Ports:
//   clk, nReset (async active-low), rst (sync active-high, loads resd)
//   cnt_en, rci  both must be high for the counter to step
//   ud           1=count up, 0=count down
//   nld          active-low parallel load of d; overrides counting
//   q            current count
module ud_cnt #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic            rst,
    input  logic            cnt_en,
    input  logic            ud,
    input  logic            nld,
    input  logic            rci,
    input  logic [SIZE-1:0] d,
    input  logic [SIZE-1:0] resd,
    output logic [SIZE-1:0] q
);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            q <= '0;
        end else if (rst) begin
            q <= resd;
        end else if (!nld) begin
            q <= d;
        end else if (cnt_en && rci) begin
            q <= ud ? q + 1'b1 : q - 1'b1;
        end
    end

endmodule

// File: rtl/pio_tctrl.sv
// rtl/pio_tctrl.sv - ATA PIO access sequencer (T1 / T2 / TEOC) driving DIOR/DIOW
// Ports:
//   clk, nReset (async active-low), rst (sync active-high, aborts an access)
//   go, we                 start an access; we and timings are sampled only on acceptance
//   T1, T2, Teoc           phase lengths minus one
//   IORDY_en, IORDY        optional device wait at the end of T2 (IORDY is asynchronous)
//   busy, oe, DIOR, DIOW   registered phase outputs
//   dstrb, done            one-cycle pulses: read capture, access complete
import pio_tctrl_pkg::*;

module pio_tctrl #(
    parameter int TWIDTH = TWIDTH_DEF
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              rst,
    input  logic              go,
    input  logic              we,
    input  logic [TWIDTH-1:0] T1,
    input  logic [TWIDTH-1:0] T2,
    input  logic [TWIDTH-1:0] Teoc,
    input  logic              IORDY_en,
    input  logic              IORDY,
    output logic              busy,
    output logic              oe,
    output logic              DIOR,
    output logic              DIOW,
    output logic              dstrb,
    output logic              done
);

    state_e            state_q, state_d;
    logic              we_q;
    logic [TWIDTH-1:0] t2_q, teoc_q;
    logic              iordy_s1_q, iordy_s_q;
    logic [TWIDTH-1:0] cnt_q, cnt_d;
    logic              cnt_ld;
    logic              cnt_zero;
    logic              accept;
    logic              we_d;

    assign cnt_zero = (cnt_q == '0);
    assign accept   = (state_q == ST_IDLE) && go;
    // Outputs are registered from the next state, so the access direction
    // must already reflect a go being accepted this cycle.
    assign we_d     = accept ? we : we_q;

    // The counter is reloaded whenever it sits at zero (and throughout IDLE),
    // so it never wraps and holds at zero during an IORDY wait.
    always_comb begin
        state_d = state_q;
        cnt_ld  = 1'b0;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                cnt_ld = 1'b1;
                if (go) begin
                    state_d = ST_T1;
                    cnt_d   = T1;
                end
            end
            ST_T1: begin
                if (cnt_zero) begin
                    cnt_ld  = 1'b1;
                    cnt_d   = t2_q;
                    state_d = ST_T2;
                end
            end
            ST_T2: begin
                if (cnt_zero) begin
                    cnt_ld = 1'b1;
                    if (!IORDY_en || iordy_s_q) begin
                        cnt_d   = teoc_q;
                        state_d = ST_TEOC;
                    end
                end
            end
            ST_TEOC: begin
                if (cnt_zero) begin
                    cnt_ld  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_ld  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            t2_q       <= '0;
            teoc_q     <= '0;
            iordy_s1_q <= 1'b0;
            iordy_s_q  <= 1'b0;
            busy       <= 1'b0;
            oe         <= 1'b0;
            DIOR       <= 1'b0;
            DIOW       <= 1'b0;
            dstrb      <= 1'b0;
            done       <= 1'b0;
        end else if (rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            t2_q       <= '0;
            teoc_q     <= '0;
            iordy_s1_q <= 1'b0;
            iordy_s_q  <= 1'b0;
            busy       <= 1'b0;
            oe         <= 1'b0;
            DIOR       <= 1'b0;
            DIOW       <= 1'b0;
            dstrb      <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            iordy_s1_q <= IORDY;
            iordy_s_q  <= iordy_s1_q;
            if (accept) begin
                we_q   <= we;
                t2_q   <= T2;
                teoc_q <= Teoc;
            end
            busy  <= (state_d != ST_IDLE);
            oe    <= we_d && (state_d != ST_IDLE);
            DIOR  <= (state_d == ST_T2) && !we_d;
            DIOW  <= (state_d == ST_T2) && we_d;
            dstrb <= (state_q == ST_T2) && (state_d == ST_TEOC) && !we_q;
            done  <= (state_q == ST_TEOC) && (state_d == ST_IDLE);
        end
    end

    ud_cnt #(
        .SIZE(TWIDTH)
    ) u_cnt (
        .clk    (clk),
        .nReset (nReset),
        .rst    (rst),
        .cnt_en (1'b1),
        .ud     (1'b0),
        .nld    (!cnt_ld),
        .rci    (1'b1),
        .d      (cnt_d),
        .resd   ('0),
        .q      (cnt_q)
    );

endmodule

// File: tb/tb_pio_tctrl.sv
// tb/tb_pio_tctrl.sv - self-checking bench for pio_tctrl
module tb_pio_tctrl;

    localparam int TW = 8;
    localparam int NC = 100;

    logic          clk = 1'b0;
    logic          nReset, rst, go, we, IORDY_en, IORDY;
    logic [TW-1:0] T1, T2, Teoc;
    logic          busy, oe, DIOR, DIOW, dstrb, done;

    int n_cmp = 0;
    int n_bad = 0;

    pio_tctrl #(.TWIDTH(TW)) dut (
        .clk(clk), .nReset(nReset), .rst(rst), .go(go), .we(we),
        .T1(T1), .T2(T2), .Teoc(Teoc), .IORDY_en(IORDY_en), .IORDY(IORDY),
        .busy(busy), .oe(oe), .DIOR(DIOR), .DIOW(DIOW), .dstrb(dstrb), .done(done)
    );

    always #5 clk = ~clk;

    // {busy, oe, DIOR, DIOW, dstrb, done}
    function automatic logic [5:0] outs();
        return {busy, oe, DIOR, DIOW, dstrb, done};
    endfunction

    // Last T2 cycle: nominal end, or two cycles after IORDY rises if that is later.
    function automatic int t2_end(int t1, int t2, bit ioen, int r);
        int e;
        e = t1 + t2 + 2;
        if (ioen && r > 0 && r + 2 > e) e = r + 2;
        return e;
    endfunction

    // Expected outputs in cycle j of an access whose go was in cycle 0.
    function automatic logic [5:0] model(int j, bit w, int t1, int teoc, int t2e);
        bit bsy, in_t2, ds, dn;
        bsy   = (j >= 1) && (j <= t2e + teoc + 1);
        in_t2 = (j >= t1 + 2) && (j <= t2e);
        ds    = (j == t2e + 1) && !w;
        dn    = (j == t2e + teoc + 2);
        return {bsy, bsy && w, in_t2 && !w, in_t2 && w, ds, dn};
    endfunction

    task automatic start_access(input bit w, input int t1, input int t2, input int teoc,
                                input bit ioen, input bit iordy0);
        int v1, v2, v3;
        v1 = t1; v2 = t2; v3 = teoc;
        IORDY_en = ioen;
        IORDY    = iordy0;
        we       = w;
        T1       = v1[TW-1:0];
        T2       = v2[TW-1:0];
        Teoc     = v3[TW-1:0];
        go       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        go = 1'b1;
    endtask

    task automatic scramble_inputs();
        go   = 1'b0;
        we   = ~we;
        T1   = TW'($urandom);
        T2   = TW'($urandom);
        Teoc = TW'($urandom);
    endtask

    // r = cycle in which IORDY goes high (0 = high throughout).
    task automatic run_access(input string name, input bit w, input int t1, input int t2,
                              input int teoc, input bit ioen, input int r);
        int t2e, last;
        logic [5:0] exp;
        t2e  = t2_end(t1, t2, ioen, r);
        last = t2e + teoc + 4;
        start_access(w, t1, t2, teoc, ioen, r == 0);
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) scramble_inputs();
            if (r > 0 && k == r) IORDY = 1'b1;
            exp = model(k, w, t1, teoc, t2e);
            n_cmp++;
            if (outs() !== exp) begin
                n_bad++;
                $display("FAIL %s cycle %0d got %b want %b", name, k, outs(), exp);
            end
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0; rst = 1'b1; go = 1'b0; we = 1'b0;
        T1 = '0; T2 = '0; Teoc = '0; IORDY_en = 1'b0; IORDY = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (outs() !== 6'b0) begin n_bad++; $display("FAIL reset_async got %b want 000000", outs()); end
        nReset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (outs() !== 6'b0) begin n_bad++; $display("FAIL reset_sync got %b want 000000", outs()); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (outs() !== 6'b0) begin n_bad++; $display("FAIL reset_release got %b want 000000", outs()); end
    endtask

    task automatic test_directed();
        run_access("read_2_3_1", 1'b0, 2, 3, 1, 1'b0, 0);
        run_access("write_0_0_0", 1'b1, 0, 0, 0, 1'b0, 0);
        run_access("iordy_wait", 1'b0, 2, 3, 1, 1'b1, 12);
        run_access("iordy_early", 1'b1, 3, 4, 2, 1'b1, 2);
        run_access("iordy_ready", 1'b0, 1, 2, 0, 1'b1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            bit w, ioen;
            int a, b, c, r;
            w    = 1'($urandom_range(0, 1));
            ioen = 1'($urandom_range(0, 1));
            a    = int'($urandom_range(0, 6));
            b    = int'($urandom_range(0, 6));
            c    = int'($urandom_range(0, 6));
            r    = ioen ? int'($urandom_range(0, 24)) : 0;
            run_access("random", w, a, b, c, ioen, r);
        end
    endtask

    task automatic test_back_to_back();
        int         pt1[NC+1], pt2[NC+1], pte[NC+1];
        bit         pw[NC+1];
        logic [5:0] expv[NC+1];
        int         s, d, t2e;
        for (int k = 0; k <= NC; k++) begin
            pt1[k] = int'($urandom_range(0, 4));
            pt2[k] = int'($urandom_range(0, 4));
            pte[k] = int'($urandom_range(0, 4));
            pw[k]  = 1'($urandom_range(0, 1));
            expv[k] = '0;
        end
        // Each access latches the inputs present in its go cycle; the next go
        // is accepted in its done cycle.
        s = 0;
        while (s < NC) begin
            d   = pt1[s] + pt2[s] + pte[s] + 4;
            t2e = pt1[s] + pt2[s] + 2;
            for (int j = 1; j <= d; j++)
                if (s + j <= NC) expv[s + j] = model(j, pw[s], pt1[s], pte[s], t2e);
            s = s + d;
        end
        IORDY_en = 1'b0;
        go = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        go = 1'b1; we = pw[0]; T1 = pt1[0][TW-1:0]; T2 = pt2[0][TW-1:0]; Teoc = pte[0][TW-1:0];
        for (int k = 1; k <= NC; k++) begin
            @(posedge clk);
            #1;
            we = pw[k]; T1 = pt1[k][TW-1:0]; T2 = pt2[k][TW-1:0]; Teoc = pte[k][TW-1:0];
            n_cmp++;
            if (outs() !== expv[k]) begin
                n_bad++;
                $display("FAIL back_to_back cycle %0d got %b want %b", k, outs(), expv[k]);
            end
        end
        go = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL back_to_back_drain busy got %b want 0", busy); end
    endtask

    task automatic test_rst_abort();
        int t2e;
        logic [5:0] exp;
        t2e = t2_end(2, 3, 1'b0, 0);
        start_access(1'b0, 2, 3, 1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) scramble_inputs();
            exp = model(k, 1'b0, 2, 1, t2e);
            n_cmp++;
            if (outs() !== exp) begin n_bad++; $display("FAIL rst_pre cycle %0d got %b want %b", k, outs(), exp); end
        end
        rst = 1'b1;
        for (int k = 6; k <= 14; k++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            n_cmp++;
            if (outs() !== 6'b0) begin n_bad++; $display("FAIL rst_abort cycle %0d got %b want 000000", k, outs()); end
        end
    endtask

    task automatic test_nreset_async();
        int t2e;
        logic [5:0] exp;
        t2e = t2_end(2, 3, 1'b0, 0);
        start_access(1'b1, 2, 3, 1, 1'b0, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            if (k == 1) scramble_inputs();
            exp = model(k, 1'b1, 2, 1, t2e);
            n_cmp++;
            if (outs() !== exp) begin n_bad++; $display("FAIL nreset_pre cycle %0d got %b want %b", k, outs(), exp); end
        end
        #2 nReset = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== 6'b0) begin n_bad++; $display("FAIL nreset_async got %b want 000000", outs()); end
        #2 nReset = 1'b1;
        for (int k = 3; k <= 10; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (outs() !== 6'b0) begin n_bad++; $display("FAIL nreset_after cycle %0d got %b want 000000", k, outs()); end
        end
    endtask

    task automatic test_max_timing();
        run_access("max_255", 1'b0, 255, 255, 255, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_rst_abort();
        test_nreset_async();
        test_max_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
